// File: rtl/sha1_pkg.sv
// sha1_pkg
//   Shared constants and types for the SHA-1 message front end.
//   Block geometry, padding constants, padder FSM state and pending-block
//   encodings, and the SHA-1 initial hash value H0..H4 for the downstream core.
package sha1_pkg;

    localparam int SHA1_BLK_W       = 512;
    localparam int SHA1_BLK_BYTES   = SHA1_BLK_W / 8;
    localparam int SHA1_LEN_FIELD_W = 64;
    localparam int SHA1_LEN_LIMIT   = 55;   // most message bytes that still leave room for 0x80 + length

    localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;
    localparam logic [159:0] SHA1_IV = {SHA1_H0, SHA1_H1, SHA1_H2, SHA1_H3, SHA1_H4};

    typedef enum logic {
        S_FILL,
        S_OUT
    } state_t;

    // What the block after the current one must contain.
    typedef enum logic [1:0] {
        NONE,
        LEN_ONLY,
        PAD_LEN
    } pend_t;

    // Bit offset of the LSB of byte lane idx inside a block (lane 0 is the MSB byte).
    function automatic logic [8:0] lane_lsb(input logic [5:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

// File: rtl/sha1_block_buf.sv
// sha1_block_buf
//   64-byte block register. Each byte lane has its own write enable; a clear
//   zeroes the whole block and a length load overwrites lanes 56..63. Within a
//   cycle the clear applies first, then lane writes, then the length load, so a
//   single cycle can start a fresh block and populate it.
// Ports
//   clk         in   1    clock
//   rst_n       in   1    asynchronous active-low reset, block goes to zero
//   clr         in   1    synchronous clear of all lanes
//   lane_we     in   64   per-lane write enable, bit i = lane i
//   lane_wdata  in   512  write data in block layout (lane 0 at [511:504])
//   len_load    in   1    load the 64-bit length field into lanes 56..63
//   len_value   in   64   big-endian length field
//   data        out  512  current block contents
module sha1_block_buf
    import sha1_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic [SHA1_BLK_BYTES-1:0]   lane_we,
    input  logic [SHA1_BLK_W-1:0]       lane_wdata,
    input  logic                        len_load,
    input  logic [SHA1_LEN_FIELD_W-1:0] len_value,
    output logic [SHA1_BLK_W-1:0]       data
);

    logic [SHA1_BLK_W-1:0] data_next;

    always_comb begin
        data_next = clr ? '0 : data;
        for (int i = 0; i < SHA1_BLK_BYTES; i++) begin
            if (lane_we[i]) begin
                data_next[lane_lsb(6'(i)) +: 8] = lane_wdata[lane_lsb(6'(i)) +: 8];
            end
        end
        if (len_load) begin
            data_next[SHA1_LEN_FIELD_W-1:0] = len_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= data_next;
        end
    end

endmodule

// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder
//   Byte-stream front end for the SHA-1 core. Collects message bytes into
//   512-bit blocks and appends the standard padding: 0x80, zeros, and the
//   64-bit big-endian message bit length. Marks the first and final block of
//   each message so the hash engine knows when to load the IV and when the
//   digest is complete.
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    message byte valid
//   in_ready   out  1    padder can accept a byte
//   in_data    in   8    message byte
//   in_last    in   1    final byte of message
//   blk_valid  out  1    padded block valid
//   blk_ready  in   1    downstream accepts block
//   blk_data   out  512  block, byte 0 at [511:504]
//   blk_first  out  1    first block of its message
//   blk_last   out  1    final block of its message (holds length field)
//
// state  | meaning
// S_FILL | accepting message bytes into the block buffer
// S_OUT  | presenting a completed block, waiting for blk_ready
module sha1_msg_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [SHA1_BLK_W-1:0] blk_data,
    output logic                  blk_first,
    output logic                  blk_last
);

    localparam logic [5:0] LAST_LANE    = 6'(SHA1_BLK_BYTES - 1);
    localparam logic [5:0] LEN_FIT_PTR  = 6'(SHA1_LEN_LIMIT - 1);

    state_t           state;
    pend_t            pend;
    logic [5:0]       ptr;
    logic [5:0]       ptr_inc;
    logic [LEN_W-1:0] bit_len;
    logic [LEN_W-1:0] len_next;

    logic [SHA1_LEN_FIELD_W-1:0] len_field_cur;
    logic [SHA1_LEN_FIELD_W-1:0] len_field_next;

    logic                        accept;
    logic                        blk_take;
    logic                        buf_clr;
    logic [SHA1_BLK_BYTES-1:0]   lane_we;
    logic [SHA1_BLK_W-1:0]       lane_wdata;
    logic                        len_load;
    logic [SHA1_LEN_FIELD_W-1:0] len_value;

    // in_ready and blk_valid are never high together, so accept and blk_take
    // are mutually exclusive.
    assign accept         = in_valid & in_ready;
    assign blk_take       = blk_valid & blk_ready;
    assign ptr_inc        = ptr + 6'd1;
    assign len_next       = bit_len + LEN_W'(8);
    assign len_field_cur  = SHA1_LEN_FIELD_W'(bit_len);
    assign len_field_next = SHA1_LEN_FIELD_W'(len_next);

    always_comb begin
        buf_clr    = 1'b0;
        lane_we    = '0;
        lane_wdata = '0;
        len_load   = 1'b0;
        len_value  = '0;
        if (accept) begin
            lane_we[ptr]                   = 1'b1;
            lane_wdata[lane_lsb(ptr) +: 8] = in_data;
            if (in_last) begin
                if (ptr != LAST_LANE) begin
                    lane_we[ptr_inc]                   = 1'b1;
                    lane_wdata[lane_lsb(ptr_inc) +: 8] = SHA1_PAD_BYTE;
                end
                if (ptr <= LEN_FIT_PTR) begin
                    len_load  = 1'b1;
                    len_value = len_field_next;
                end
            end
        end else if (blk_take) begin
            // Every hand-off starts from an empty buffer; a pending trailer
            // block is built in the same cycle from the latched bit length.
            buf_clr = 1'b1;
            if (!blk_last && pend == PAD_LEN) begin
                lane_we[0]                           = 1'b1;
                lane_wdata[SHA1_BLK_W-1 -: 8]        = SHA1_PAD_BYTE;
            end
            if (!blk_last && pend != NONE) begin
                len_load  = 1'b1;
                len_value = len_field_cur;
            end
        end
    end

    sha1_block_buf u_block_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (buf_clr),
        .lane_we    (lane_we),
        .lane_wdata (lane_wdata),
        .len_load   (len_load),
        .len_value  (len_value),
        .data       (blk_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            pend      <= NONE;
            ptr       <= '0;
            bit_len   <= '0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_first <= 1'b1;
            blk_last  <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (!in_ready) begin
                        // first cycle out of reset
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        bit_len <= len_next;
                        if (!in_last && ptr != LAST_LANE) begin
                            ptr <= ptr_inc;
                        end else begin
                            state     <= S_OUT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            if (!in_last) begin
                                blk_last <= 1'b0;
                                pend     <= NONE;
                            end else if (ptr <= LEN_FIT_PTR) begin
                                blk_last <= 1'b1;
                                pend     <= NONE;
                            end else if (ptr != LAST_LANE) begin
                                blk_last <= 1'b0;
                                pend     <= LEN_ONLY;
                            end else begin
                                blk_last <= 1'b0;
                                pend     <= PAD_LEN;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (blk_ready) begin
                        if (blk_last) begin
                            state     <= S_FILL;
                            pend      <= NONE;
                            ptr       <= '0;
                            bit_len   <= '0;
                            in_ready  <= 1'b1;
                            blk_valid <= 1'b0;
                            blk_first <= 1'b1;
                            blk_last  <= 1'b0;
                        end else if (pend == NONE) begin
                            state     <= S_FILL;
                            ptr       <= '0;
                            in_ready  <= 1'b1;
                            blk_valid <= 1'b0;
                            blk_first <= 1'b0;
                        end else begin
                            // trailer block is loaded this edge, stay presenting
                            pend      <= NONE;
                            blk_first <= 1'b0;
                            blk_last  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder
//   Directed vectors for the SHA-1 padder. Expected blocks are pushed into a
//   queue when a message is issued; a monitor pops and compares on each block
//   hand-off.
module tb_sha1_msg_padder;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [511:0] exp_data_q[$];
    logic         exp_first_q[$];
    logic         exp_last_q[$];
    string        exp_name_q[$];
    logic [7:0]   msg_q[$];

    localparam logic [511:0] BLK_ABC = {24'h616263, 8'h80, 416'h0, 64'h18};
    localparam logic [511:0] BLK_DE  = {16'h6465, 8'h80, 424'h0, 64'h10};

    sha1_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: a hand-off happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            n_cmp++;
            if (exp_data_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_block got data=%h first=%b last=%b", blk_data, blk_first, blk_last);
            end else begin
                logic [511:0] ed;
                logic         ef;
                logic         el;
                string        en;
                ed = exp_data_q.pop_front();
                ef = exp_first_q.pop_front();
                el = exp_last_q.pop_front();
                en = exp_name_q.pop_front();
                if (blk_data !== ed || blk_first !== ef || blk_last !== el) begin
                    n_err++;
                    $display("FAIL %s got data=%h f=%b l=%b exp data=%h f=%b l=%b", en, blk_data, blk_first, blk_last, ed, ef, el);
                end
            end
        end
    end

    task automatic expect_blk(input string name, input logic [511:0] d, input logic f, input logic l);
        exp_name_q.push_back(name);
        exp_data_q.push_back(d);
        exp_first_q.push_back(f);
        exp_last_q.push_back(l);
    endtask

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present one byte and hold it until the padder takes it.
    task automatic put_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_msg();
        for (int i = 0; i < msg_q.size(); i++) begin
            put_byte(msg_q[i], i == msg_q.size() - 1);
        end
        msg_q.delete();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_data_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (exp_data_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain got=%0d pending exp=0", name, exp_data_q.size());
            exp_data_q.delete();
            exp_first_q.delete();
            exp_last_q.delete();
            exp_name_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"},  512'(in_ready),  512'(0));
        check({name, "_blk_valid"}, 512'(blk_valid), 512'(0));
        check({name, "_blk_data"},  blk_data,        512'(0));
        check({name, "_blk_first"}, 512'(blk_first), 512'(1));
        check({name, "_blk_last"},  512'(blk_last),  512'(0));
    endtask

    logic [447:0] msg56;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        blk_ready = 1'b1;
        msg56     = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: "abc", with a stray in_last without in_valid beforehand
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        expect_blk("abc", BLK_ABC, 1'b1, 1'b1);
        push_str("abc");
        send_msg();
        wait_drain("abc");

        // 2: 56-byte message, length spills into a second block
        expect_blk("m56_b0", {msg56, 8'h80, 56'h0}, 1'b1, 1'b0);
        expect_blk("m56_b1", {448'h0, 64'h1C0}, 1'b0, 1'b1);
        for (int i = 0; i < 56; i++) msg_q.push_back(msg56[447 - 8*i -: 8]);
        send_msg();
        wait_drain("m56");

        // 3: 64 bytes of 'a', padding byte and length in a second block
        expect_blk("a64_b0", {64{8'h61}}, 1'b1, 1'b0);
        expect_blk("a64_b1", {8'h80, 440'h0, 64'h200}, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) msg_q.push_back(8'h61);
        send_msg();
        wait_drain("a64");

        // 4: 55 zero bytes, the largest message that fits a single block
        expect_blk("z55", 512'h80_00000000000001B8, 1'b1, 1'b1);
        for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
        send_msg();
        wait_drain("z55");

        // 5: backpressure on "abc", then two back-to-back messages
        blk_ready = 1'b0;
        expect_blk("bp_abc", BLK_ABC, 1'b1, 1'b1);
        push_str("abc");
        send_msg();
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!blk_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        for (int c = 0; c < 5; c++) begin
            check("bp_blk_valid", 512'(blk_valid), 512'(1));
            check("bp_blk_data",  blk_data,        BLK_ABC);
            check("bp_in_ready",  512'(in_ready),  512'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
        expect_blk("b2b_abc", BLK_ABC, 1'b1, 1'b1);
        expect_blk("b2b_de",  BLK_DE,  1'b1, 1'b1);
        push_str("abc");
        send_msg();
        push_str("de");
        send_msg();
        wait_drain("b2b");

        // 6: reset in the middle of a message
        for (int i = 0; i < 20; i++) put_byte(8'(8'h30 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_blk("post_rst_abc", BLK_ABC, 1'b1, 1'b1);
        push_str("abc");
        send_msg();
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
